// File: rtl/me_pkg.sv
// Shared types and defaults for the block-match frame sequencer.
// State encoding, default memory depths and motion-vector field slicing.
package me_pkg;

    localparam int unsigned ME_DATA_WIDTH     = 8;
    localparam int unsigned ME_RB_DEPTH       = 256;
    localparam int unsigned ME_SW_DEPTH       = 961;
    localparam int unsigned ME_CAND_COUNT     = 256;
    localparam int unsigned ME_SAD_WIDTH      = 16;
    localparam int unsigned ME_COMPUTE_CYCLES = 4111;

    localparam int unsigned ME_RB_AW = $clog2(ME_RB_DEPTH);
    localparam int unsigned ME_SW_AW = $clog2(ME_SW_DEPTH);

    // Candidate index is row-major over the 16x16 displacement grid.
    localparam int unsigned ME_IDX_WIDTH = 8;
    localparam int unsigned ME_MV_WIDTH  = 4;
    localparam int unsigned ME_MV_X_LSB  = 0;
    localparam int unsigned ME_MV_Y_LSB  = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLoadRb,
        StLoadSw,
        StCompute,
        StDrain,
        StDone
    } me_state_e;

endpackage

// File: rtl/me_min_tracker.sv
// Running minimum of candidate SADs; strict compare so ties keep the earlier index.
module me_min_tracker #(
    parameter int unsigned SAD_WIDTH = 16,
    parameter int unsigned IDX_WIDTH = 8
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_clear,
    input  logic                 in_valid,
    input  logic [SAD_WIDTH-1:0] in_sad,
    input  logic [IDX_WIDTH-1:0] in_idx,
    output logic [SAD_WIDTH-1:0] out_best_sad,
    output logic [IDX_WIDTH-1:0] out_best_idx
);

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            out_best_sad <= '1;
            out_best_idx <= '0;
        end else if (in_clear) begin
            out_best_sad <= '1;
            out_best_idx <= '0;
        end else if (in_valid && (in_sad < out_best_sad)) begin
            out_best_sad <= in_sad;
            out_best_idx <= in_idx;
        end
    end

endmodule

// File: rtl/me_frame_sequencer.sv
// Block-match sequencer: loads RB then SW memories, runs the PE control unit, tracks best SAD.
// Optional ME_EARLY_TERM_EN: a zero SAD ends the block early and raises out_early_term.
module me_frame_sequencer
    import me_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = ME_DATA_WIDTH,
    parameter int unsigned RB_MEMORY_DEPTH = ME_RB_DEPTH,
    parameter int unsigned SW_MEMORY_DEPTH = ME_SW_DEPTH,
    parameter int unsigned CAND_COUNT      = ME_CAND_COUNT,
    parameter int unsigned SAD_WIDTH       = ME_SAD_WIDTH,
    parameter int unsigned COMPUTE_CYCLES  = ME_COMPUTE_CYCLES
) (
    input  logic                               in_clk,
    input  logic                               in_rst,
    input  logic                               in_start,
    input  logic [DATA_WIDTH-1:0]              in_pix_data,
    input  logic                               in_pix_valid,
    output logic                               out_pix_ready,
    output logic [DATA_WIDTH-1:0]              out_wr_data,
    output logic                               out_rb_wr_en,
    output logic [$clog2(RB_MEMORY_DEPTH)-1:0] out_rb_wr_addr,
    output logic                               out_sw_wr_en,
    output logic [$clog2(SW_MEMORY_DEPTH)-1:0] out_sw_wr_addr,
    output logic                               out_cu_rst,
    output logic                               out_cu_ena,
    input  logic                               in_sad_valid,
    input  logic [SAD_WIDTH-1:0]               in_sad,
    output logic                               out_busy,
    output logic                               out_done,
    output logic [SAD_WIDTH-1:0]               out_best_sad,
    output logic [ME_MV_WIDTH-1:0]             out_best_mv_x,
    output logic [ME_MV_WIDTH-1:0]             out_best_mv_y
`ifdef ME_EARLY_TERM_EN
    ,
    output logic                               out_early_term
`endif
);

    localparam int unsigned RB_AW = $clog2(RB_MEMORY_DEPTH);
    localparam int unsigned SW_AW = $clog2(SW_MEMORY_DEPTH);
    localparam int unsigned CYC_W = $clog2(COMPUTE_CYCLES);
    localparam int unsigned CNT_W = $clog2(CAND_COUNT + 1);

    me_state_e               state;
    logic [RB_AW-1:0]        rb_cnt;
    logic [SW_AW-1:0]        sw_cnt;
    logic [CYC_W-1:0]        cyc_cnt;
    logic [CNT_W-1:0]        cand_cnt;
    logic [CNT_W-1:0]        cand_cnt_inc;
    logic [ME_IDX_WIDTH-1:0] best_idx;
    logic beat, sad_accept, cand_last, cyc_last, rb_last, sw_last, early_hit, entry_clear;

    assign out_pix_ready = (state == StLoadRb) || (state == StLoadSw);
    assign out_busy      = (state != StIdle);
    assign beat          = in_pix_valid && out_pix_ready;
    assign entry_clear   = (state == StIdle) && in_start;

    // Candidates are only counted while the datapath can produce them, and never past the quota.
    assign sad_accept   = in_sad_valid && ((state == StCompute) || (state == StDrain))
                          && (cand_cnt != CNT_W'(CAND_COUNT));
    assign cand_cnt_inc = cand_cnt + CNT_W'(sad_accept);
    assign cand_last    = (cand_cnt_inc == CNT_W'(CAND_COUNT));
    assign rb_last      = (rb_cnt == RB_AW'(RB_MEMORY_DEPTH - 1));
    assign sw_last      = (sw_cnt == SW_AW'(SW_MEMORY_DEPTH - 1));
    assign cyc_last     = (cyc_cnt == CYC_W'(COMPUTE_CYCLES - 1));

`ifdef ME_EARLY_TERM_EN
    assign early_hit = sad_accept && (in_sad == '0);
`else
    assign early_hit = 1'b0;
`endif

    me_min_tracker #(
        .SAD_WIDTH (SAD_WIDTH),
        .IDX_WIDTH (ME_IDX_WIDTH)
    ) u_min_tracker (
        .in_clk       (in_clk),
        .in_rst       (in_rst),
        .in_clear     (entry_clear),
        .in_valid     (sad_accept),
        .in_sad       (in_sad),
        .in_idx       (cand_cnt[ME_IDX_WIDTH-1:0]),
        .out_best_sad (out_best_sad),
        .out_best_idx (best_idx)
    );

    assign out_best_mv_x = best_idx[ME_MV_X_LSB +: ME_MV_WIDTH];
    assign out_best_mv_y = best_idx[ME_MV_Y_LSB +: ME_MV_WIDTH];

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state          <= StIdle;
            rb_cnt         <= '0;
            sw_cnt         <= '0;
            cyc_cnt        <= '0;
            cand_cnt       <= '0;
            out_wr_data    <= '0;
            out_rb_wr_en   <= 1'b0;
            out_rb_wr_addr <= '0;
            out_sw_wr_en   <= 1'b0;
            out_sw_wr_addr <= '0;
            out_cu_rst     <= 1'b1;
            out_cu_ena     <= 1'b0;
            out_done       <= 1'b0;
`ifdef ME_EARLY_TERM_EN
            out_early_term <= 1'b0;
`endif
        end else begin
            out_rb_wr_en <= 1'b0;
            out_sw_wr_en <= 1'b0;
            out_done     <= 1'b0;
            if (beat) begin
                out_wr_data <= in_pix_data;
            end
            if (sad_accept) begin
                cand_cnt <= cand_cnt_inc;
            end
`ifdef ME_EARLY_TERM_EN
            if (entry_clear) begin
                out_early_term <= 1'b0;
            end else if (early_hit) begin
                out_early_term <= 1'b1;
            end
`endif
            unique case (state)
                StIdle: begin
                    if (in_start) begin
                        state    <= StLoadRb;
                        rb_cnt   <= '0;
                        sw_cnt   <= '0;
                        cand_cnt <= '0;
                    end
                end
                StLoadRb: begin
                    if (beat) begin
                        out_rb_wr_en   <= 1'b1;
                        out_rb_wr_addr <= rb_cnt;
                        rb_cnt         <= rb_cnt + RB_AW'(1);
                        if (rb_last) begin
                            state <= StLoadSw;
                        end
                    end
                end
                StLoadSw: begin
                    if (beat) begin
                        out_sw_wr_en   <= 1'b1;
                        out_sw_wr_addr <= sw_cnt;
                        sw_cnt         <= sw_cnt + SW_AW'(1);
                        if (sw_last) begin
                            state      <= StCompute;
                            cyc_cnt    <= '0;
                            out_cu_rst <= 1'b0;
                            out_cu_ena <= 1'b1;
                        end
                    end
                end
                StCompute: begin
                    cyc_cnt <= cyc_cnt + CYC_W'(1);
                    if (early_hit || cyc_last) begin
                        out_cu_ena <= 1'b0;
                        out_cu_rst <= 1'b1;
                    end
                    // Last candidate landing on the expiry cycle skips DRAIN entirely.
                    if (early_hit || (cyc_last && cand_last)) begin
                        state    <= StDone;
                        out_done <= 1'b1;
                    end else if (cyc_last) begin
                        state <= StDrain;
                    end
                end
                StDrain: begin
                    if (early_hit || cand_last) begin
                        state    <= StDone;
                        out_done <= 1'b1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
